// File: rtl/csa_stream_accumulator_if.sv
// csa_stream_accumulator_if: operand stream in, carry-save result pair out (out_total with CSA_STREAM_ACCUMULATOR_FINAL_ADD_EN)
interface csa_stream_accumulator_if #(
   parameter int WIDTH     = 16,
   parameter int ACC_WIDTH = 24,
   parameter int CNT_WIDTH = 8
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     in_data;
   logic                 in_last;
   logic                 out_valid;
   logic                 out_ready;
   logic [ACC_WIDTH-1:0] out_sum;
   logic [ACC_WIDTH-1:0] out_carry;
   logic [CNT_WIDTH-1:0] out_count;
`ifdef CSA_STREAM_ACCUMULATOR_FINAL_ADD_EN
   logic [ACC_WIDTH-1:0] out_total;
   modport master (output in_valid, in_data, in_last, out_ready,
                   input in_ready, out_valid, out_sum, out_carry, out_count, out_total);
   modport slave  (input in_valid, in_data, in_last, out_ready,
                   output in_ready, out_valid, out_sum, out_carry, out_count, out_total);
`else
   modport master (output in_valid, in_data, in_last, out_ready,
                   input in_ready, out_valid, out_sum, out_carry, out_count);
   modport slave  (input in_valid, in_data, in_last, out_ready,
                   output in_ready, out_valid, out_sum, out_carry, out_count);
`endif
endinterface

// File: rtl/csa_stream_accumulator.sv
// csa_stream_accumulator: carry-save multi-operand group accumulator; CSA_STREAM_ACCUMULATOR_FINAL_ADD_EN adds a registered final sum
`ifdef CSA_STREAM_ACCUMULATOR_FINAL_ADD_EN
module csa_stream_accumulator_cpa #(
   parameter int W = 24
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] s
);
   assign s = a + b;
endmodule
`endif

module csa_stream_accumulator #(
   parameter int WIDTH     = 16,
   parameter int ACC_WIDTH = 24,
   parameter int CNT_WIDTH = 8
) (
   input logic                    clk,
   input logic                    rst_n,
   csa_stream_accumulator_if.slave bus
);
`ifdef CSA_STREAM_ACCUMULATOR_FINAL_ADD_EN
   typedef enum logic [1:0] {ACCUM, FINAL, HOLD} state_t;
`else
   typedef enum logic {ACCUM, HOLD} state_t;
`endif
   state_t               state_q, state_d;
   logic [ACC_WIDTH-1:0] s_q, s_d, c_q, c_d, x;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 live_q, live_d, accept;
   assign x             = ACC_WIDTH'(bus.in_data);
   assign bus.in_ready  = live_q && state_q == ACCUM;
   assign accept        = bus.in_valid && bus.in_ready;
   assign bus.out_valid = state_q == HOLD;
   assign bus.out_sum   = s_q;
   assign bus.out_carry = c_q;
   assign bus.out_count = cnt_q;
`ifdef CSA_STREAM_ACCUMULATOR_FINAL_ADD_EN
   logic [ACC_WIDTH-1:0] tot_q, tot_d, sum_w;
   csa_stream_accumulator_cpa #(.W(ACC_WIDTH)) u_cpa (.a(s_q), .b(c_q), .s(sum_w));
   assign bus.out_total = tot_q;
`endif
   // next state: one 3:2 compressor row per accepted beat, cleared on result handshake
   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      c_d     = c_q;
      cnt_d   = cnt_q;
      live_d  = 1'b1;
`ifdef CSA_STREAM_ACCUMULATOR_FINAL_ADD_EN
      tot_d   = tot_q;
`endif
      case (state_q)
         ACCUM: if (accept) begin
            s_d   = s_q ^ c_q ^ x;
            c_d   = ((s_q & c_q) | (s_q & x) | (c_q & x)) << 1;
            cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
`ifdef CSA_STREAM_ACCUMULATOR_FINAL_ADD_EN
            state_d = bus.in_last ? FINAL : ACCUM;
`else
            state_d = bus.in_last ? HOLD : ACCUM;
`endif
         end
`ifdef CSA_STREAM_ACCUMULATOR_FINAL_ADD_EN
         FINAL: begin
            tot_d   = sum_w;
            state_d = HOLD;
         end
`endif
         HOLD: if (bus.out_ready) begin
            s_d     = '0;
            c_d     = '0;
            cnt_d   = '0;
            state_d = ACCUM;
         end
         default: state_d = ACCUM;
      endcase
   end
   // state registers; live_q holds in_ready low until the first edge after reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ACCUM;
         s_q     <= '0;
         c_q     <= '0;
         cnt_q   <= '0;
         live_q  <= 1'b0;
`ifdef CSA_STREAM_ACCUMULATOR_FINAL_ADD_EN
         tot_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
         live_q  <= live_d;
`ifdef CSA_STREAM_ACCUMULATOR_FINAL_ADD_EN
         tot_q   <= tot_d;
`endif
      end
   end
endmodule

// File: tb/tb_csa_stream_accumulator.sv
// tb_csa_stream_accumulator: scoreboard bench for csa_stream_accumulator (honours CSA_STREAM_ACCUMULATOR_FINAL_ADD_EN)
module tb_csa_stream_accumulator;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_pass = 0;
   logic [31:0] sb_q[$];
   logic [23:0] m_sum = '0;
   logic [7:0]  m_cnt = '0;

   csa_stream_accumulator_if #(.WIDTH(16), .ACC_WIDTH(24), .CNT_WIDTH(8)) bus ();

   csa_stream_accumulator #(.WIDTH(16), .ACC_WIDTH(24), .CNT_WIDTH(8)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [15:0] d, input logic last);
      logic rdy;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = last;
      rdy = 1'b0;
      for (int i = 0; i < 50 && !rdy; i++) begin
         rdy = bus.in_ready;
         tick();
      end
      if (!rdy) check("beat_timeout", 0, 1);
      bus.in_valid = 1'b0;
      m_sum = m_sum + 24'(d);
      m_cnt = &m_cnt ? m_cnt : m_cnt + 8'd1;
      if (last) begin
         sb_q.push_back({m_cnt, m_sum});
         m_sum = '0;
         m_cnt = '0;
      end
   endtask

   task automatic drain(input int stall);
      logic [31:0] e;
      logic [23:0] t, ss, sc;
      logic [7:0]  sn;
      bus.out_ready = 1'b0;
`ifdef CSA_STREAM_ACCUMULATOR_FINAL_ADD_EN
      check("final_valid", 32'(bus.out_valid), 0);
      check("final_ready", 32'(bus.in_ready), 0);
      tick();
`endif
      check("lat_valid", 32'(bus.out_valid), 1);
      check("hold_ready", 32'(bus.in_ready), 0);
      if (sb_q.size() == 0) begin
         check("sb_empty", 0, 1);
         e = '0;
      end else e = sb_q.pop_front();
      t = bus.out_sum + bus.out_carry;
      check("sum_carry", 32'(t), 32'(e[23:0]));
      check("count", 32'(bus.out_count), 32'(e[31:24]));
      check("carry_lsb", 32'(bus.out_carry[0]), 0);
`ifdef CSA_STREAM_ACCUMULATOR_FINAL_ADD_EN
      check("total", 32'(bus.out_total), 32'(e[23:0]));
`endif
      ss = bus.out_sum;
      sc = bus.out_carry;
      sn = bus.out_count;
      for (int i = 0; i < stall; i++) begin
         tick();
         check("stall_valid", 32'(bus.out_valid), 1);
         check("stall_ready", 32'(bus.in_ready), 0);
         check("stall_sum", 32'(bus.out_sum), 32'(ss));
         check("stall_carry", 32'(bus.out_carry), 32'(sc));
         check("stall_count", 32'(bus.out_count), 32'(sn));
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("post_ready", 32'(bus.in_ready), 1);
      check("post_valid", 32'(bus.out_valid), 0);
   endtask

   initial begin
      int len;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;
      #12;
      check("rst_ready", 32'(bus.in_ready), 0);
      check("rst_valid", 32'(bus.out_valid), 0);
      check("rst_sum", 32'(bus.out_sum), 0);
      check("rst_carry", 32'(bus.out_carry), 0);
      check("rst_count", 32'(bus.out_count), 0);
      #3 rst_n = 1'b1;
      tick();
      check("first_ready", 32'(bus.in_ready), 1);
      // single beat
      beat(16'h1234, 1'b1);
      check("single_sum", 32'(bus.out_sum), 32'h001234);
      check("single_carry", 32'(bus.out_carry), 0);
      check("single_count", 32'(bus.out_count), 1);
      drain(0);
      // three 0xFFFF; out_ready high during accumulation must be ignored
      bus.out_ready = 1'b1;
      beat(16'hFFFF, 1'b0);
      beat(16'hFFFF, 1'b0);
      beat(16'hFFFF, 1'b1);
      check("three_total", 32'(24'(bus.out_sum + bus.out_carry)), 32'h02FFFD);
      drain(0);
      // backpressure with a pending beat that must wait for the handshake
      beat(16'h0101, 1'b0);
      beat(16'h0202, 1'b1);
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h0777;
      bus.in_last  = 1'b1;
      drain(5);
      beat(16'h0777, 1'b1);
      drain(0);
      // wrap and saturation
      for (int i = 0; i < 257; i++) beat(16'hFFFF, i == 256);
      check("wrap_total", 32'(24'(bus.out_sum + bus.out_carry)), 32'h00FEFF);
      check("sat_count", 32'(bus.out_count), 32'hFF);
      drain(1);
      // reset mid-group
      beat(16'h0003, 1'b0);
      beat(16'h0004, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_valid", 32'(bus.out_valid), 0);
      check("midrst_ready", 32'(bus.in_ready), 0);
      check("midrst_sum", 32'(bus.out_sum), 0);
      check("midrst_count", 32'(bus.out_count), 0);
      #1 rst_n = 1'b1;
      m_sum = '0;
      m_cnt = '0;
      tick();
      check("rel_ready", 32'(bus.in_ready), 1);
      beat(16'h0005, 1'b1);
      drain(0);
      // random groups
      for (int g = 0; g < 8; g++) begin
         len = $urandom_range(1, 6);
         for (int i = 0; i < len; i++) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            beat(16'($urandom), i == len - 1);
         end
         drain($urandom_range(0, 2));
      end
      check("sb_drained", 32'(sb_q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/csa_stream_accumulator.md
Name: csa_stream_accumulator

Overview:
- Multi-operand accumulator that sits directly upstream of the team's parallel-prefix (Kogge-Stone) final adder.
- Accepts a valid/ready stream of unsigned operands grouped by an in_last marker.
- Reduces each group in carry-save form with one 3:2 compressor row per beat, so there is no carry propagation in the loop.
- Emits the redundant sum/carry pair for the downstream carry-propagate adder to resolve.

Parameters:
- WIDTH, 16, operand width in bits.
- ACC_WIDTH, 24, accumulator width. All arithmetic is modulo 2^ACC_WIDTH. Must be >= WIDTH.
- CNT_WIDTH, 8, width of the beat counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat.
- in_data  input  WIDTH  unsigned operand, zero-extended to ACC_WIDTH.
- in_last  input  1  beat is the final operand of its group.
- out_valid  output  1  result pair valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  ACC_WIDTH  carry-save sum vector.
- out_carry  output  ACC_WIDTH  carry-save carry vector, already shifted left by 1.
- out_count  output  CNT_WIDTH  number of beats in the group, saturating.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. While rst_n is low:
  - S = 0, C = 0, count = 0, state = ACCUM.
  - in_ready = 0, out_valid = 0, out_sum = 0, out_carry = 0, out_count = 0.
- After release, in_ready = 1 from the first clock edge.
- State ACCUM:
  - in_ready = 1 and out_valid = 0.
  - A beat is accepted on in_valid & in_ready. On acceptance, with X = zero-extended in_data:
    - S <= S ^ C ^ X
    - C <= ((S&C)|(S&X)|(C&X)) << 1, truncated to ACC_WIDTH; bit 0 is always 0.
    - count <= min(count+1, 2^CNT_WIDTH-1).
  - If in_last is set on the accepted beat, go to HOLD.
- State HOLD:
  - in_ready = 0, out_valid = 1.
  - out_sum, out_carry and out_count present the registered S, C and count, and stay stable until the handshake.
  - On out_ready: clear S, C and count to 0 and return to ACCUM.
- Latency: out_valid rises on the cycle after the in_last beat is accepted.
- Throughput: one beat per cycle inside a group, plus a minimum of 1 dead input cycle per group (the HOLD cycle).
- Invariant: (out_sum + out_carry) mod 2^ACC_WIDTH equals the sum of all group operands mod 2^ACC_WIDTH.
- Boundary conditions:
  - Single-beat group: out_sum = X, out_carry = 0, out_count = 1.
  - Overflow beyond ACC_WIDTH wraps silently; there is no flag.
  - out_count saturates at all-ones; S and C keep accumulating.
  - in_valid while in HOLD is not accepted. The upstream source must hold its data.
  - out_ready while in ACCUM is ignored.
  - rst_n asserted mid-group discards the partial group immediately, without a clock edge.
  - rst_n asserted in HOLD drops out_valid immediately; the result is lost.

Optional Feature:
- Macro: CSA_STREAM_ACCUMULATOR_FINAL_ADD_EN.
- When defined:
  - Adds output port out_total (ACC_WIDTH), a registered out_sum + out_carry mod 2^ACC_WIDTH, computed by an internal carry-propagate adder instance.
  - Inserts a state FINAL between ACCUM and HOLD. In FINAL, in_ready = 0 and out_valid = 0, and out_total is registered.
  - out_valid therefore rises 2 cycles after the in_last beat is accepted.
  - out_total resets to 0.
- When undefined: the out_total port and the FINAL state are absent, and latency is 1 cycle.

Test Plan (WIDTH=16, ACC_WIDTH=24, CNT_WIDTH=8):
1. Single beat: in_data=0x1234 with in_last.
   - Next cycle: out_valid=1, out_sum=0x001234, out_carry=0x000000, out_count=1.
2. Three beats of 0xFFFF, the last with in_last.
   - out_sum+out_carry = 0x02FFFD, out_carry[0]=0, out_count=3.
   - Handshake with out_ready=1: the next cycle has in_ready=1 and internal state cleared.
3. Backpressure: hold out_ready=0 for 5 cycles in HOLD while in_valid=1.
   - in_ready=0 throughout; outputs remain bit-stable; no beat is consumed.
   - The pending beat is accepted in the cycle after the handshake.
4. Wrap and saturation: 257 beats of 0xFFFF, the last with in_last.
   - (out_sum+out_carry) mod 2^24 = 0x00FEFF; out_count=0xFF.
5. Reset mid-group: accept 0x0003 and 0x0004 (no last), then pulse rst_n low between clock edges.
   - out_valid=0 and in_ready=0 immediately.
   - After release, a group of 0x0005 with in_last yields sum+carry = 0x000005 and out_count=1.
6. Build with CSA_STREAM_ACCUMULATOR_FINAL_ADD_EN and rerun scenario 2.
   - out_valid rises 2 cycles after the last beat; out_total=0x02FFFD.
   - in_ready=0 during FINAL.
